circ_queue: RTL and testbench
=============================

CIRC_QUEUE -- requirements
Module: circ_queue

Interface
REQ-001 SHALL have parameter WL, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, storage entries (>=2, any integer, power of two not required).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, COUNT at or above which AFULL asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, COUNT at or below which AEMPTY asserts.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wReq  input  1  push request.
REQ-008 SHALL have port rReq  input  1  pop request.
REQ-009 SHALL have port din  input  WL  push data.
REQ-010 SHALL have port dout  output  WL  registered pop data.
REQ-011 SHALL have port dValid  output  1  dout holds a newly popped word this cycle.
REQ-012 SHALL have port COUNT  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 SHALL have ports FULL, EMPTY, AFULL, AEMPTY  output  1 each  occupancy flags.
REQ-014 SHALL have ports OVF, UDF  output  1 each  overflow/underflow error flags.

Function
REQ-015 SHALL store entries in a DEPTH-entry circular buffer with read and write pointers in range 0..DEPTH-1, each wrapping from DEPTH-1 to 0.
REQ-016 SHALL derive FULL = (COUNT==DEPTH), EMPTY = (COUNT==0), AFULL = (COUNT>=AF_LEVEL), AEMPTY = (COUNT<=AE_LEVEL), all combinationally from the COUNT register.
REQ-017 SHALL accept a push when wReq=1 and (FULL=0 or accepted pop same cycle); accepted push writes din at write pointer and advances it.
REQ-018 SHALL accept a pop when rReq=1 and EMPTY=0; accepted pop loads dout with entry at read pointer on that edge, advances read pointer, and sets dValid=1 for exactly one cycle.
REQ-019 SHALL hold dout unchanged and drive dValid=0 in any cycle without an accepted pop.
REQ-020 SHALL on simultaneous accepted push and pop leave COUNT unchanged; when FULL, both accepted; when EMPTY, push accepted, pop rejected (no bypass, UDF rule applies).
REQ-021 SHALL increment COUNT on push-only, decrement on pop-only; COUNT never exceeds DEPTH nor underflows.
REQ-022 SHALL on rejected push (wReq=1, FULL=1, no accepted pop) drop din, leave storage and pointers unchanged, and raise OVF.
REQ-023 SHALL on rejected pop (rReq=1, EMPTY=1) leave dout and pointers unchanged, keep dValid=0, and raise UDF.
REQ-024 SHALL treat all inputs as don't-care for X-propagation only while RST=1.

Reset
REQ-025 SHALL on RST=1, immediately and independent of CLK, clear both pointers, COUNT, dout, dValid, OVF, UDF to 0 (hence EMPTY=1, FULL=0, AEMPTY=1, AFULL=0 if AF_LEVEL>0).
REQ-026 SHALL on reset mid-operation discard all stored entries; storage array contents need not be cleared.
REQ-027 SHALL ignore wReq/rReq on the first CLK edge coinciding with RST=1 and resume normal operation on the first edge after RST deasserts.

Configuration
REQ-028 SHALL support macro CIRC_QUEUE_STICKY_ERR_EN.
REQ-029 SHALL with CIRC_QUEUE_STICKY_ERR_EN defined hold OVF/UDF at 1 once set until RST.
REQ-030 SHALL with CIRC_QUEUE_STICKY_ERR_EN undefined drive OVF/UDF high for exactly the one cycle following each rejected request, else 0.

Verification
REQ-031 SHALL verify fill/drain: WL=8, DEPTH=5, push 0x11..0x15 -> FULL=1, COUNT=5; pop x5 -> dout 0x11..0x15 in order, each with dValid=1 one cycle after rReq, then EMPTY=1.
REQ-032 SHALL verify wrap-around: DEPTH=5, 3 pushes/3 pops, then 5 pushes 0xA0..0xA4 and 5 pops -> order preserved across pointer wrap, COUNT returns 0.
REQ-033 SHALL verify boundaries: wReq at FULL without rReq -> OVF=1, COUNT stays 5, data unaltered; rReq at EMPTY -> UDF=1, dValid=0, dout unchanged.
REQ-034 SHALL verify simultaneous: at FULL wReq=rReq=1 with din=0x5A -> oldest word popped, COUNT stays 5, 0x5A read last; at EMPTY both -> COUNT=1, UDF=1.
REQ-035 SHALL verify flags and reset: AF_LEVEL=4, AE_LEVEL=1 -> AFULL at COUNT 4, AEMPTY at COUNT<=1; RST pulse mid-edge at COUNT=3 -> COUNT=0, EMPTY=1, dValid=0 asynchronously.
REQ-036 SHALL verify both macro builds: two consecutive overflows then idle -> sticky build OVF stays 1 until RST; non-sticky build OVF=1 only in the cycle after each overflow.

Source files
------------

// File: rtl/circ_queue.sv
// Circular FIFO with registered pop data, occupancy flags and overflow/underflow error flags.
// Define CIRC_QUEUE_STICKY_ERR_EN to make OVF/UDF sticky until reset.
module circ_queue #(
  parameter int WL       = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wReq,
  input  logic                       rReq,
  input  logic [WL-1:0]              din,
  output logic [WL-1:0]              dout,
  output logic                       dValid,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       AFULL,
  output logic                       AEMPTY,
  output logic                       OVF,
  output logic                       UDF
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WL-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_ev;
  logic          udf_ev;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    FULL    = (COUNT == CW'(DEPTH));
    EMPTY   = (COUNT == '0);
    AFULL   = (int'(COUNT) >= AF_LEVEL);
    AEMPTY  = (int'(COUNT) <= AE_LEVEL);
    // A full queue can still take a push when a pop frees a slot on the same edge.
    pop_ok  = rReq && !EMPTY;
    push_ok = wReq && (!FULL || pop_ok);
    ovf_ev  = wReq && !push_ok;
    udf_ev  = rReq && !pop_ok;
  end

  // NOTE: storage has no reset; only pointers and COUNT define what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      dout   <= '0;
      dValid <= 1'b0;
      OVF    <= 1'b0;
      UDF    <= 1'b0;
    end else begin
      dValid <= pop_ok;
      if (push_ok) wr_ptr <= bump(wr_ptr);
      if (pop_ok) begin
        rd_ptr <= bump(rd_ptr);
        dout   <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
`ifdef CIRC_QUEUE_STICKY_ERR_EN
      OVF <= OVF | ovf_ev;
      UDF <= UDF | udf_ev;
`else
      OVF <= ovf_ev;
      UDF <= udf_ev;
`endif
    end
  end

endmodule

// File: tb/tb_circ_queue.sv
// Scoreboard bench for circ_queue (WL=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1); a monitor checks popped words.
module tb_circ_queue;

`ifdef CIRC_QUEUE_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       wReq;
  logic       rReq;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dValid;
  logic [2:0] COUNT;
  logic       FULL, EMPTY, AFULL, AEMPTY, OVF, UDF;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  circ_queue #(.WL(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .CLK(CLK), .RST(RST), .wReq(wReq), .rReq(rReq), .din(din),
    .dout(dout), .dValid(dValid), .COUNT(COUNT),
    .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY),
    .OVF(OVF), .UDF(UDF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs after a falling edge, return at the next falling edge.
  task automatic op(input logic w, input logic r, input logic [7:0] d);
    wReq = w;
    rReq = r;
    din  = d;
    @(negedge CLK);
    wReq = 1'b0;
    rReq = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    op(1'b1, 1'b0, d);
  endtask

  task automatic pop(input logic [7:0] exp);
    exp_q.push_back(exp);
    op(1'b0, 1'b1, 8'h00);
  endtask

  // Monitor: every dValid must match the oldest expected word.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && dValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dvalid", {24'd0, dout}, 32'hFFFF_FFFF);
        end else begin
          check("pop_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    RST = 1'b1; wReq = 1'b0; rReq = 1'b0; din = 8'h00;
    #1;
    check("rst_count", {29'd0, COUNT}, 0);
    check("rst_flags", {26'd0, FULL, EMPTY, AFULL, AEMPTY, OVF, UDF}, 32'b010100);
    check("rst_dout_dvalid", {23'd0, dValid, dout}, 0);
    // Requests on an edge while RST is high are ignored.
    wReq = 1'b1; rReq = 1'b1; din = 8'hCC;
    @(negedge CLK);
    check("rst_ignores_req", {29'd0, COUNT}, 0);
    wReq = 1'b0; rReq = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Fill: AFULL from COUNT 4, AEMPTY while COUNT <= 1.
    for (int i = 1; i <= 5; i++) begin
      push(8'h10 + 8'(i));
      check("fill_count", {29'd0, COUNT}, i);
      check("fill_af_ae", {30'd0, AFULL, AEMPTY}, {30'd0, (i >= 4), (i <= 1)});
    end
    check("full_flags", {30'd0, FULL, EMPTY}, 32'b10);

    // Two back-to-back overflows, then idle.
    push(8'hEE);
    check("ovf1", {30'd0, OVF, UDF}, 32'b10);
    push(8'hEF);
    check("ovf2", {29'd0, COUNT}, 5);
    check("ovf2_flag", {31'd0, OVF}, 1);
    op(1'b0, 1'b0, 8'h00);
    check("ovf_idle", {31'd0, OVF}, {31'd0, STICKY});
    op(1'b0, 1'b0, 8'h00);
    check("ovf_idle2", {31'd0, OVF}, {31'd0, STICKY});

    // Push+pop at FULL: oldest leaves, 0x5A goes in last.
    exp_q.push_back(8'h11);
    op(1'b1, 1'b1, 8'h5A);
    check("full_both_count", {29'd0, COUNT}, 5);
    pop(8'h12); pop(8'h13); pop(8'h14); pop(8'h15); pop(8'h5A);
    check("drained", {29'd0, COUNT, EMPTY}, {29'd0, 3'd0, 1'b1});

    // Underflow: dout holds its last value, no dValid.
    op(1'b0, 1'b1, 8'h00);
    check("udf_flag", {31'd0, UDF}, 1);
    check("udf_dout", {23'd0, dValid, dout}, {23'd0, 1'b0, 8'h5A});
    check("udf_count", {29'd0, COUNT}, 0);

    // Push+pop at EMPTY: push taken, pop rejected.
    op(1'b1, 1'b1, 8'h77);
    check("empty_both_count", {29'd0, COUNT}, 1);
    check("empty_both_udf", {31'd0, UDF}, 1);
    check("empty_both_dvalid", {31'd0, dValid}, 0);
    pop(8'h77);
    check("udf_after", {31'd0, UDF}, {31'd0, STICKY});

    // Wrap-around across the 5-entry buffer.
    push(8'h01); push(8'h02); push(8'h03);
    pop(8'h01); pop(8'h02); pop(8'h03);
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    check("wrap_full", {30'd0, FULL, AFULL}, 32'b11);
    for (int i = 0; i < 5; i++) pop(8'hA0 + 8'(i));
    check("wrap_count", {29'd0, COUNT}, 0);

    // Asynchronous reset mid-cycle with COUNT=3 and dValid high.
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    pop(8'h21);
    check("pre_rst", {28'd0, dValid, COUNT}, {28'd0, 1'b1, 3'd3});
    #2 RST = 1'b1;
    #1;
    check("async_rst_count", {29'd0, COUNT}, 0);
    check("async_rst_flags", {26'd0, FULL, EMPTY, AFULL, AEMPTY, OVF, UDF}, 32'b010100);
    check("async_rst_dvalid", {23'd0, dValid, dout}, 0);
    @(negedge CLK);
    RST = 1'b0;
    push(8'h33);
    pop(8'h33);
    check("post_rst_count", {29'd0, COUNT}, 0);

    op(1'b0, 1'b0, 8'h00);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
